// File: rtl/uart_cmd_assembler.sv
// Receives three UART bytes (MSB first) into a 24-bit command with an inter-byte timeout,
// and drives single-byte responses into the UART transmitter.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  typedef enum logic [1:0] {IDLE, B1, B2, HOLD} rx_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [23:0]      cmd_q, cmd_d;
  logic             clr_rdy_q, clr_rdy_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             accept;
  logic             timeout;

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic             resp_sent_q, resp_sent_d;

  // clr_rdy_q masks the falling edge of rdy so one byte is never captured twice
  assign accept  = rdy && !clr_rdy_q && (rx_state_q != HOLD);
  assign timeout = (gap_q == GAP_LAST) && !accept;

  always_comb begin
    rx_state_d  = rx_state_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    cmd_d       = cmd_q;
    frame_err_d = 1'b0;
    gap_d       = '0;
    clr_rdy_d   = accept;
    case (rx_state_q)
      IDLE: begin
        if (accept) begin
          byte0_d    = rx_data;
          rx_state_d = B1;
        end
      end
      B1: begin
        if (accept) begin
          byte1_d    = rx_data;
          rx_state_d = B2;
        end else if (timeout) begin
          byte0_d     = '0;
          byte1_d     = '0;
          frame_err_d = 1'b1;
          rx_state_d  = IDLE;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      B2: begin
        if (accept) begin
          cmd_d      = {byte0_q, byte1_q, rx_data};
          rx_state_d = HOLD;
        end else if (timeout) begin
          byte0_d     = '0;
          byte1_d     = '0;
          frame_err_d = 1'b1;
          rx_state_d  = IDLE;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) rx_state_d = IDLE;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= IDLE;
      byte0_q     <= '0;
      byte1_q     <= '0;
      cmd_q       <= '0;
      clr_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      cmd_q       <= cmd_d;
      clr_rdy_q   <= clr_rdy_d;
      frame_err_q <= frame_err_d;
      gap_q       <= gap_d;
    end
  end

  // tx_done seen while trmt_q is high is the previous byte's stale level
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (send_resp) begin
        tx_data_d  = resp_data;
        trmt_d     = 1'b1;
        tx_state_d = TX_BUSY;
      end
    end else begin
      if (tx_done && !trmt_q) begin
        resp_sent_d = 1'b1;
        tx_state_d  = TX_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign clr_rdy   = clr_rdy_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = (rx_state_q == HOLD);
  assign frame_err = frame_err_q;
  assign tx_busy   = (tx_state_q == TX_BUSY);
  assign resp_sent = resp_sent_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: command assembly, hold/backpressure, timeout,
// timeout boundary, response transmit and mid-operation reset.
module tb_uart_cmd_assembler;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst, rdy, clr_rdy, cmd_rdy, clr_cmd_rdy, frame_err;
  logic [7:0]  rx_data, resp_data, tx_data;
  logic [23:0] cmd;
  logic        send_resp, tx_busy, resp_sent, trmt, tx_done;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned ack_cnt = 0;
  int unsigned ferr_cnt = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .resp_data(resp_data), .send_resp(send_resp), .tx_busy(tx_busy),
    .resp_sent(resp_sent), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_rdy === 1'b1) ack_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART receiver model: raise rdy, expect clr_rdy after exactly one edge, drop rdy one cycle later
  task automatic send_byte(input logic [7:0] b, input string nm, output logic crdy);
    int unsigned n;
    n = 0;
    rdy = 1'b1;
    rx_data = b;
    do begin
      tick();
      n++;
    end while (clr_rdy !== 1'b1 && n < 40);
    crdy = cmd_rdy;
    vectors++;
    if (clr_rdy !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL %s_ack: clr_rdy=%b after %0d cycles, expected 1 after 1", nm, clr_rdy, n);
    end
    tick();
    vectors++;
    if (clr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_single_ack: clr_rdy=%b expected 0", nm, clr_rdy);
    end
    rdy = 1'b0;
  endtask

  task automatic release_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    resp_data = '0; send_resp = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({clr_rdy, cmd_rdy, frame_err, tx_busy, resp_sent, trmt, tx_data, cmd} !== 38'h0) begin
      errors++;
      $display("FAIL reset: outputs=%h expected 0",
               {clr_rdy, cmd_rdy, frame_err, tx_busy, resp_sent, trmt, tx_data, cmd});
    end
  endtask

  task automatic test_three_bytes();
    int unsigned a0;
    logic c;
    a0 = ack_cnt;
    send_byte(8'hA5, "tb_b0", c);
    vectors++;
    if (c !== 1'b0) begin errors++; $display("FAIL early_cmd_rdy: cmd_rdy=%b expected 0", c); end
    send_byte(8'h3C, "tb_b1", c);
    send_byte(8'h0F, "tb_b2", c);
    vectors++;
    if (c !== 1'b1) begin errors++; $display("FAIL cmd_rdy_latency: cmd_rdy=%b expected 1", c); end
    vectors++;
    if (cmd !== 24'hA53C0F) begin errors++; $display("FAIL cmd_a53c0f: cmd=%h expected a53c0f", cmd); end
    vectors++;
    if (ack_cnt - a0 != 3) begin errors++; $display("FAIL ack_count: %0d pulses expected 3", ack_cnt - a0); end
  endtask

  task automatic test_hold();
    int unsigned a0;
    logic c;
    a0 = ack_cnt;
    rdy = 1'b1;
    rx_data = 8'h11;
    repeat (3) tick();
    vectors++;
    if (ack_cnt != a0 || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hold_backpressure: acks=%0d cmd_rdy=%b expected 0 and 1", ack_cnt - a0, cmd_rdy);
    end
    release_cmd();
    vectors++;
    if (cmd_rdy !== 1'b0 || clr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: cmd_rdy=%b clr_rdy=%b expected 0 0", cmd_rdy, clr_rdy);
    end
    tick();
    vectors++;
    if (clr_rdy !== 1'b1 || cmd !== 24'hA53C0F) begin
      errors++;
      $display("FAIL hold_next_byte: clr_rdy=%b cmd=%h expected 1 a53c0f", clr_rdy, cmd);
    end
    tick();
    rdy = 1'b0;
    send_byte(8'h22, "hold_b1", c);
    send_byte(8'h33, "hold_b2", c);
    vectors++;
    if (c !== 1'b1 || cmd !== 24'h112233) begin
      errors++;
      $display("FAIL cmd_112233: cmd=%h cmd_rdy=%b expected 112233 1", cmd, c);
    end
    release_cmd();
  endtask

  task automatic test_timeout();
    int unsigned f0, at;
    logic c;
    f0 = ferr_cnt;
    at = 0;
    send_byte(8'h01, "to_b0", c);
    send_byte(8'h02, "to_b1", c);
    for (int i = 1; i <= int'(TO) + 5; i++) begin
      tick();
      if (frame_err === 1'b1 && at == 0) at = i;
    end
    vectors++;
    if (at != TO - 1) begin errors++; $display("FAIL ferr_timing: pulse at %0d expected %0d", at, TO - 1); end
    vectors++;
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_width: %0d high cycles expected 1", ferr_cnt - f0); end
    vectors++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'h112233) begin
      errors++;
      $display("FAIL ferr_cmd_kept: cmd=%h cmd_rdy=%b expected 112233 0", cmd, cmd_rdy);
    end
    send_byte(8'hC0, "to_n0", c);
    send_byte(8'hFF, "to_n1", c);
    send_byte(8'hEE, "to_n2", c);
    vectors++;
    if (c !== 1'b1 || cmd !== 24'hC0FFEE) begin
      errors++;
      $display("FAIL cmd_c0ffee: cmd=%h cmd_rdy=%b expected c0ffee 1", cmd, c);
    end
    release_cmd();
  endtask

  task automatic test_boundary();
    int unsigned f0;
    logic c;
    f0 = ferr_cnt;
    send_byte(8'h12, "bd_b0", c);
    send_byte(8'h34, "bd_b1", c);
    repeat (TO - 2) tick();
    send_byte(8'h56, "bd_b2", c);
    vectors++;
    if (c !== 1'b1 || cmd !== 24'h123456 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL timeout_boundary: cmd=%h cmd_rdy=%b ferr=%0d expected 123456 1 0",
               cmd, c, ferr_cnt - f0);
    end
    release_cmd();
  endtask

  task automatic test_tx();
    tx_done = 1'b1;
    resp_data = 8'h5A;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    vectors++;
    if ({trmt, tx_busy, resp_sent} !== 3'b110 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL trmt_pulse: trmt/busy/sent=%b tx_data=%h expected 110 5a", {trmt, tx_busy, resp_sent}, tx_data);
    end
    tick();
    vectors++;
    if ({trmt, tx_busy, resp_sent} !== 3'b010) begin
      errors++;
      $display("FAIL stale_done_masked: trmt/busy/sent=%b expected 010", {trmt, tx_busy, resp_sent});
    end
    tx_done = 1'b0;
    resp_data = 8'h77;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    repeat (3) tick();
    vectors++;
    if (trmt !== 1'b0 || tx_data !== 8'h5A || tx_busy !== 1'b1 || resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: trmt=%b tx_data=%h busy=%b sent=%b expected 0 5a 1 0",
               trmt, tx_data, tx_busy, resp_sent);
    end
    tx_done = 1'b1;
    tick();
    vectors++;
    if (resp_sent !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL resp_sent: sent=%b busy=%b expected 1 0", resp_sent, tx_busy);
    end
    tick();
    vectors++;
    if (resp_sent !== 1'b0 || trmt !== 1'b0 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL no_queue: sent=%b trmt=%b tx_data=%h expected 0 0 5a", resp_sent, trmt, tx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic c;
    tx_done = 1'b0;
    send_byte(8'h9A, "rm_b0", c);
    send_byte(8'hBC, "rm_b1", c);
    resp_data = 8'hE1;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({clr_rdy, cmd_rdy, frame_err, tx_busy, resp_sent, trmt, tx_data, cmd} !== 38'h0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h expected 0",
               {clr_rdy, cmd_rdy, frame_err, tx_busy, resp_sent, trmt, tx_data, cmd});
    end
    resp_data = 8'h3C;
    send_resp = 1'b1;
    rdy = 1'b1;
    rx_data = 8'hAB;
    tick();
    send_resp = 1'b0;
    vectors++;
    if (trmt !== 1'b1 || clr_rdy !== 1'b1 || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL simultaneous: trmt=%b clr_rdy=%b tx_data=%h expected 1 1 3c", trmt, clr_rdy, tx_data);
    end
    tick();
    rdy = 1'b0;
    send_byte(8'hCD, "rm_n1", c);
    send_byte(8'hEF, "rm_n2", c);
    vectors++;
    if (c !== 1'b1 || cmd !== 24'hABCDEF) begin
      errors++;
      $display("FAIL cmd_abcdef: cmd=%h cmd_rdy=%b expected abcdef 1", cmd, c);
    end
    tx_done = 1'b1;
    tick();
    vectors++;
    if (resp_sent !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL resp_after_reset: sent=%b busy=%b expected 1 0", resp_sent, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_three_bytes();
    test_hold();
    test_timeout();
    test_boundary();
    test_tx();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
